// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator / pulse width meter pair:
// one-hot meter state encodings and the default counter width.
package pulse_pkg;

  localparam int PW_W = 16;

  typedef enum logic [2:0] {
    ST_WAIT_LOW = 3'b001,
    ST_IDLE     = 3'b010,
    ST_MEASURE  = 3'b100
  } pw_state_e;

endpackage

// File: rtl/pulse_sync2.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear to 0.
module pulse_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the high time of pulse_in in clk cycles and reports each completed width.
// Define PULSE_SYNC_EN to pass pulse_in through a 2-flop synchronizer (+2 cycles latency).
module pulse_width_meter
  import pulse_pkg::*;
#(
  parameter int W         = PW_W,
  parameter int MIN_WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         pulse_in,
  input  logic [W-1:0] expected_width,
  output logic [W-1:0] width_out,
  output logic         width_valid,
  output logic         match,
  output logic         overflow,
  output logic         runt,
  output logic         busy
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] MIN_CNT = W'(MIN_WIDTH);

  pw_state_e    r_state;
  pw_state_e    w_state_nxt;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic         r_ovf;
  logic         w_ovf_nxt;
  logic         w_report;
  logic         w_runt;
  logic         w_pulse_s;

`ifdef PULSE_SYNC_EN
  pulse_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pulse_in),
    .o_q   (w_pulse_s)
  );
`else
  assign w_pulse_s = pulse_in;
`endif

  // WAIT_LOW holds off until the line is seen low, so a pulse already in
  // progress at reset release or enable rise is never measured.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_report    = 1'b0;
    w_runt      = 1'b0;
    unique case (r_state)
      ST_WAIT_LOW: begin
        if (enable && !w_pulse_s) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!enable) begin
          w_state_nxt = ST_WAIT_LOW;
        end else if (w_pulse_s) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = W'(1);
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (w_pulse_s) begin
          if (r_cnt == CNT_MAX) w_ovf_nxt = 1'b1;
          else                  w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          if (r_cnt >= MIN_CNT) w_report = 1'b1;
          else                  w_runt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOW;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT_LOW;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      width_out   <= '0;
      width_valid <= 1'b0;
      match       <= 1'b0;
      overflow    <= 1'b0;
      runt        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      width_valid <= w_report;
      runt        <= w_runt;
      // Result fields only move on a real report; runts leave them untouched.
      if (w_report) begin
        width_out <= r_cnt;
        match     <= (r_cnt == expected_width);
        overflow  <= r_ovf;
      end
    end
  end

  assign busy = (r_state == ST_MEASURE);

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter (W=8, MIN_WIDTH=2); honours PULSE_SYNC_EN for latency.
module tb_pulse_width_meter;

  localparam int W = 8;
`ifdef PULSE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         pulse_in;
  logic [W-1:0] expected_width;
  logic [W-1:0] width_out;
  logic         width_valid;
  logic         match;
  logic         overflow;
  logic         runt;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int busy_cnt = 0;

  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           runt_cyc_q[$];
  logic [W+1:0] mon_e;
  int           mon_c;

  pulse_width_meter #(.W(W), .MIN_WIDTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .pulse_in       (pulse_in),
    .expected_width (expected_width),
    .width_out      (width_out),
    .width_valid    (width_valid),
    .match          (match),
    .overflow       (overflow),
    .runt           (runt),
    .busy           (busy)
  );

  // clock / reset-time counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks: all driving happens 1 time unit after a rising edge
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_high(input int n);
    pulse_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    pulse_in = 1'b0;
  endtask

  task automatic expect_width(input logic [W-1:0] w, input logic m, input logic o);
    exp_q.push_back({w, m, o});
    exp_cyc_q.push_back(cyc + LAT);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (width_valid || runt) chk("valid_runt_excl", 32'(width_valid && runt), 32'(0));
      if (width_valid) begin
        chk("valid_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          chk("valid_cycle", 32'(cyc), 32'(mon_c));
          chk("width_out", 32'(width_out), 32'(mon_e[W+1:2]));
          chk("match", 32'(match), 32'(mon_e[1]));
          chk("overflow", 32'(overflow), 32'(mon_e[0]));
        end
      end
      if (runt) begin
        chk("runt_expected", 32'(runt_cyc_q.size() != 0), 32'(1));
        if (runt_cyc_q.size() != 0) begin
          mon_c = runt_cyc_q.pop_front();
          chk("runt_cycle", 32'(cyc), 32'(mon_c));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    pulse_in = 1'b1;
    expected_width = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_width_out", 32'(width_out), 32'(0));
    chk("rst_width_valid", 32'(width_valid), 32'(0));
    chk("rst_match", 32'(match), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_runt", 32'(runt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // pulse present across reset release and enable rise: ignored, next pulse measured
    busy_cnt = 0;
    idle_cycles(3);
    enable = 1'b1;
    idle_cycles(7);
    pulse_in = 1'b0;
    chk("partial_busy", 32'(busy_cnt), 32'(0));
    idle_cycles(4);
    expected_width = 8'd3;
    hold_high(3);
    expect_width(8'd3, 1'b1, 1'b0);
    idle_cycles(6);
    chk("partial_width_out", 32'(width_out), 32'(3));

    // basic 5-cycle pulse
    expected_width = 8'd5;
    busy_cnt = 0;
    hold_high(5);
    expect_width(8'd5, 1'b1, 1'b0);
    idle_cycles(6);
    chk("basic_busy_cycles", 32'(busy_cnt), 32'(5));

    // saturation at 2^W-1
    expected_width = 8'd10;
    hold_high(300);
    expect_width(8'd255, 1'b0, 1'b1);
    idle_cycles(6);

    // report 7, then a 1-cycle runt; results hold even though expected_width moves
    expected_width = 8'd7;
    hold_high(7);
    expect_width(8'd7, 1'b1, 1'b0);
    idle_cycles(6);
    expected_width = 8'd9;
    hold_high(1);
    runt_cyc_q.push_back(cyc + LAT);
    idle_cycles(6);
    chk("runt_hold_width", 32'(width_out), 32'(7));
    chk("runt_hold_match", 32'(match), 32'(1));
    chk("runt_hold_ovf", 32'(overflow), 32'(0));

    // back-to-back with a 1-cycle gap
    expected_width = 8'd6;
    hold_high(4);
    expect_width(8'd4, 1'b0, 1'b0);
    idle_cycles(1);
    hold_high(6);
    expect_width(8'd6, 1'b1, 1'b0);
    idle_cycles(6);

    // abort by enable drop mid-pulse, re-enable while still high, then a clean pulse
    expected_width = 8'd2;
    pulse_in = 1'b1;
    idle_cycles(3);
    chk("abort_busy_before", 32'(busy), 32'(1));
    enable = 1'b0;
    idle_cycles(1);
    chk("abort_busy_after", 32'(busy), 32'(0));
    idle_cycles(2);
    enable = 1'b1;
    idle_cycles(4);
    chk("reenable_busy", 32'(busy), 32'(0));
    pulse_in = 1'b0;
    idle_cycles(4);
    hold_high(2);
    expect_width(8'd2, 1'b1, 1'b0);
    idle_cycles(6);
    chk("abort_final_width", 32'(width_out), 32'(2));

    chk("pending_reports", 32'(exp_q.size()), 32'(0));
    chk("pending_runts", 32'(runt_cyc_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
